// File: rtl/cp0_regfile_if.sv
// mtc0 / exception / read-back bundle between the pre-memory stage and CP0.
// Member names follow the pipeline's existing signal names.
interface cp0_regfile_if;
  logic [31:0] inst1_c0_wdata;
  logic [7:0]  inst1_c0_addr;
  logic        inst1_mtc0_we;
  logic [31:0] inst2_c0_wdata;
  logic [7:0]  inst2_c0_addr;
  logic        inst2_mtc0_we;
  logic        pms_ex;
  logic [4:0]  ex_type;
  logic        pms_bd;
  logic [31:0] pms_pc;
  logic [31:0] pms_badvaddr;
  logic        pms_eret;
  logic [5:0]  ext_int;
  logic [31:0] inst1_c0_rdata;
  logic [31:0] inst2_c0_rdata;
  logic        has_int;
  logic [31:0] pms_epc;

  modport master (
    output inst1_c0_wdata, inst1_c0_addr, inst1_mtc0_we,
    output inst2_c0_wdata, inst2_c0_addr, inst2_mtc0_we,
    output pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret, ext_int,
    input  inst1_c0_rdata, inst2_c0_rdata, has_int, pms_epc
  );

  modport slave (
    input  inst1_c0_wdata, inst1_c0_addr, inst1_mtc0_we,
    input  inst2_c0_wdata, inst2_c0_addr, inst2_mtc0_we,
    input  pms_ex, ex_type, pms_bd, pms_pc, pms_badvaddr, pms_eret, ext_int,
    output inst1_c0_rdata, inst2_c0_rdata, has_int, pms_epc
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: dual mtc0 write slots, exception/eret updates, Count/Compare timer.
// Define CP0_TLB_REGS_EN to add Index, EntryLo0/1 and EntryHi.
module cp0_regfile #(
  parameter int COUNT_DIV = 1
) (
  input logic          clk,
  input logic          resetn,
  cp0_regfile_if.slave bus
);

  localparam logic [7:0] A_BADV   = 8'h40;
  localparam logic [7:0] A_COUNT  = 8'h48;
  localparam logic [7:0] A_CMP    = 8'h58;
  localparam logic [7:0] A_STATUS = 8'h60;
  localparam logic [7:0] A_CAUSE  = 8'h68;
  localparam logic [7:0] A_EPC    = 8'h70;
`ifdef CP0_TLB_REGS_EN
  localparam logic [7:0] A_INDEX  = 8'h00;
  localparam logic [7:0] A_ELO0   = 8'h10;
  localparam logic [7:0] A_ELO1   = 8'h18;
  localparam logic [7:0] A_EHI    = 8'h50;
`endif

  logic [COUNT_DIV-1:0] r_tick;
  logic [31:0] r_count, r_compare, r_epc, r_badvaddr;
  logic        r_ti, r_exl, r_ie, r_bd;
  logic [7:0]  r_im;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [5:0]  r_ext_q;

  logic [32:0] w_wr_status, w_wr_cause, w_wr_epc, w_wr_count, w_wr_compare;
  logic [31:0] w_status, w_cause;
  logic        w_tick_wrap, w_addr_ex, w_has_int, w_unused;

`ifdef CP0_TLB_REGS_EN
  logic [3:0]  r_index;
  logic [25:0] r_elo0, r_elo1;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic [32:0] w_wr_index, w_wr_elo0, w_wr_elo1, w_wr_ehi;
  logic        w_unused_tlb;
`endif

  // Slot 2 is younger, so its data wins when both slots hit the same register.
  function automatic logic [32:0] wr_pick(input logic [7:0] a);
    if (bus.inst2_mtc0_we && (bus.inst2_c0_addr == a)) begin
      return {1'b1, bus.inst2_c0_wdata};
    end else if (bus.inst1_mtc0_we && (bus.inst1_c0_addr == a)) begin
      return {1'b1, bus.inst1_c0_wdata};
    end else begin
      return 33'd0;
    end
  endfunction

  function automatic logic [31:0] rd_mux(input logic [7:0] a);
    case (a)
      A_BADV:   return r_badvaddr;
      A_COUNT:  return r_count;
      A_CMP:    return r_compare;
      A_STATUS: return w_status;
      A_CAUSE:  return w_cause;
      A_EPC:    return r_epc;
`ifdef CP0_TLB_REGS_EN
      A_INDEX:  return {28'd0, r_index};
      A_ELO0:   return {6'd0, r_elo0};
      A_ELO1:   return {6'd0, r_elo1};
      A_EHI:    return {r_vpn2, 5'd0, r_asid};
`endif
      default:  return 32'd0;
    endcase
  endfunction

  always_comb begin
    w_wr_status  = wr_pick(A_STATUS);
    w_wr_cause   = wr_pick(A_CAUSE);
    w_wr_epc     = wr_pick(A_EPC);
    w_wr_count   = wr_pick(A_COUNT);
    w_wr_compare = wr_pick(A_CMP);
    w_tick_wrap  = &r_tick;
    w_addr_ex    = (bus.ex_type >= 5'd2) && (bus.ex_type <= 5'd5);
    w_status     = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    w_cause      = {r_bd, r_ti, 14'd0, r_ext_q[5] | r_ti, r_ext_q[4:0], r_ip_sw, 1'b0, r_exccode, 2'd0};
    w_has_int    = (|(w_cause[15:8] & r_im)) & r_ie & ~r_exl;
    w_unused     = ^{w_wr_status[31:16], w_wr_status[7:2], w_wr_cause[31:10], w_wr_cause[7:0]};
    bus.inst1_c0_rdata = rd_mux(bus.inst1_c0_addr);
    bus.inst2_c0_rdata = rd_mux(bus.inst2_c0_addr);
    bus.has_int        = w_has_int;
    bus.pms_epc        = r_epc;
  end

  // Count/Compare timer; a Count write overrides the increment, a Compare write clears TI.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick    <= '0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= r_tick + COUNT_DIV'(1'b1);
      if (w_wr_count[32]) r_count <= w_wr_count[31:0];
      else if (w_tick_wrap) r_count <= r_count + 32'd1;
      if (w_wr_compare[32]) begin
        r_compare <= w_wr_compare[31:0];
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  // Status/Cause/EPC/BadVAddr; exception and eret assignments come last so they win.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_ip_sw    <= 2'd0;
      r_bd       <= 1'b0;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_ext_q    <= 6'd0;
    end else begin
      r_ext_q <= bus.ext_int;
      if (w_wr_status[32]) begin
        r_im  <= w_wr_status[15:8];
        r_exl <= w_wr_status[1];
        r_ie  <= w_wr_status[0];
      end
      if (w_wr_cause[32]) r_ip_sw <= w_wr_cause[9:8];
      if (w_wr_epc[32]) r_epc <= w_wr_epc[31:0];
      if (bus.pms_ex) begin
        r_exl     <= 1'b1;
        r_exccode <= bus.ex_type;
        if (!r_exl) begin
          r_epc <= bus.pms_bd ? (bus.pms_pc - 32'd4) : bus.pms_pc;
          r_bd  <= bus.pms_bd;
        end
        if (w_addr_ex) r_badvaddr <= bus.pms_badvaddr;
      end else if (bus.pms_eret) begin
        r_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_TLB_REGS_EN
  always_comb begin
    w_wr_index   = wr_pick(A_INDEX);
    w_wr_elo0    = wr_pick(A_ELO0);
    w_wr_elo1    = wr_pick(A_ELO1);
    w_wr_ehi     = wr_pick(A_EHI);
    w_unused_tlb = ^{w_wr_index[31:4], w_wr_elo0[31:26], w_wr_elo1[31:26], w_wr_ehi[12:8]};
  end

  // TLB-facing registers; a TLBL/TLBS exception reloads VPN2 over any same-cycle write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_index <= 4'd0;
      r_elo0  <= 26'd0;
      r_elo1  <= 26'd0;
      r_vpn2  <= 19'd0;
      r_asid  <= 8'd0;
    end else begin
      if (w_wr_index[32]) r_index <= w_wr_index[3:0];
      if (w_wr_elo0[32]) r_elo0 <= w_wr_elo0[25:0];
      if (w_wr_elo1[32]) r_elo1 <= w_wr_elo1[25:0];
      if (w_wr_ehi[32]) begin
        r_vpn2 <= w_wr_ehi[31:13];
        r_asid <= w_wr_ehi[7:0];
      end
      if (bus.pms_ex && ((bus.ex_type == 5'd2) || (bus.ex_type == 5'd3))) begin
        r_vpn2 <= bus.pms_badvaddr[31:13];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed plus randomized bench for cp0_regfile, checked against a word-level register model.
module tb_cp0_regfile;
  localparam int COUNT_DIV = 1;
  localparam int PERIOD    = 1 << COUNT_DIV;
  localparam logic [7:0] ADDRS [0:9] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70,
                                         8'h00, 8'h10, 8'h18, 8'h50};

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cp0_regfile_if bus ();
  cp0_regfile #(.COUNT_DIV(COUNT_DIV)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_reg [0:255];
  logic [5:0]  m_extq;
  int          m_edges;

  function automatic logic [31:0] wmask(input logic [7:0] a);
    case (a)
      8'h48, 8'h58, 8'h70: return 32'hFFFF_FFFF;
      8'h60:               return 32'h0000_FF03;
      8'h68:               return 32'h0000_0300;
`ifdef CP0_TLB_REGS_EN
      8'h00:               return 32'h0000_000F;
      8'h10, 8'h18:        return 32'h03FF_FFFF;
      8'h50:               return 32'hFFFF_E0FF;
`endif
      default:             return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    logic [31:0] v;
    v = m_reg[a];
    if (a == 8'h68) begin
      v = v | {16'd0, m_extq, 10'd0};
      if (v[30]) v[15] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic exp_has_int();
    logic [31:0] c, s;
    c = exp_read(8'h68);
    s = m_reg[8'h60];
    return (|(c[15:8] & s[15:8])) && s[0] && !s[1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = 32'd0;
    m_reg[8'h60] = 32'h0040_0000;
    m_extq  = 6'd0;
    m_edges = 0;
  endtask

  task automatic model_edge();
    logic [31:0] old_count, old_cmp;
    logic old_exl, wrote_count, wrote_cmp;
    m_edges++;
    old_count = m_reg[8'h48];
    old_cmp   = m_reg[8'h58];
    old_exl   = m_reg[8'h60][1];
    if (bus.inst1_mtc0_we)
      m_reg[bus.inst1_c0_addr] = (m_reg[bus.inst1_c0_addr] & ~wmask(bus.inst1_c0_addr)) |
                                 (bus.inst1_c0_wdata & wmask(bus.inst1_c0_addr));
    if (bus.inst2_mtc0_we)
      m_reg[bus.inst2_c0_addr] = (m_reg[bus.inst2_c0_addr] & ~wmask(bus.inst2_c0_addr)) |
                                 (bus.inst2_c0_wdata & wmask(bus.inst2_c0_addr));
    wrote_count = (bus.inst1_mtc0_we && bus.inst1_c0_addr == 8'h48) ||
                  (bus.inst2_mtc0_we && bus.inst2_c0_addr == 8'h48);
    wrote_cmp   = (bus.inst1_mtc0_we && bus.inst1_c0_addr == 8'h58) ||
                  (bus.inst2_mtc0_we && bus.inst2_c0_addr == 8'h58);
    if (!wrote_count && (m_edges % PERIOD == 0)) m_reg[8'h48] = old_count + 32'd1;
    if (wrote_cmp) m_reg[8'h68][30] = 1'b0;
    else if (old_count == old_cmp) m_reg[8'h68][30] = 1'b1;
    if (bus.pms_ex) begin
      m_reg[8'h68][6:2] = bus.ex_type;
      if (!old_exl) begin
        m_reg[8'h70]     = bus.pms_bd ? bus.pms_pc - 32'd4 : bus.pms_pc;
        m_reg[8'h68][31] = bus.pms_bd;
      end
      m_reg[8'h60][1] = 1'b1;
      if (bus.ex_type inside {5'd2, 5'd3, 5'd4, 5'd5}) m_reg[8'h40] = bus.pms_badvaddr;
`ifdef CP0_TLB_REGS_EN
      if (bus.ex_type inside {5'd2, 5'd3}) m_reg[8'h50][31:13] = bus.pms_badvaddr[31:13];
`endif
    end else if (bus.pms_eret) begin
      m_reg[8'h60][1] = 1'b0;
    end
    m_extq = bus.ext_int;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_idle();
    bus.inst1_mtc0_we = 1'b0; bus.inst1_c0_addr = 8'd0; bus.inst1_c0_wdata = 32'd0;
    bus.inst2_mtc0_we = 1'b0; bus.inst2_c0_addr = 8'd0; bus.inst2_c0_wdata = 32'd0;
    bus.pms_ex = 1'b0; bus.ex_type = 5'd0; bus.pms_bd = 1'b0; bus.pms_pc = 32'd0;
    bus.pms_badvaddr = 32'd0; bus.pms_eret = 1'b0; bus.ext_int = 6'd0;
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return ADDRS[r];
    else return 8'($urandom);
  endfunction

  task automatic check_all();
    logic [7:0] a1, a2;
    a1 = pick_addr();
    a2 = pick_addr();
    bus.inst1_c0_addr = a1;
    bus.inst2_c0_addr = a2;
    #1;
    chk($sformatf("rd1@%h", a1), bus.inst1_c0_rdata, exp_read(a1));
    chk($sformatf("rd2@%h", a2), bus.inst2_c0_rdata, exp_read(a2));
    chk("has_int", {31'd0, bus.has_int}, {31'd0, exp_has_int()});
    chk("pms_epc", bus.pms_epc, m_reg[8'h70]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    set_idle();
    check_all();
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] v);
    bus.inst1_c0_addr = a;
    #1;
    v = bus.inst1_c0_rdata;
  endtask

  task automatic mtc0(input bit we1, input logic [7:0] a1, input logic [31:0] d1,
                      input bit we2, input logic [7:0] a2, input logic [31:0] d2);
    bus.inst1_mtc0_we = we1; bus.inst1_c0_addr = a1; bus.inst1_c0_wdata = d1;
    bus.inst2_mtc0_we = we2; bus.inst2_c0_addr = a2; bus.inst2_c0_wdata = d2;
    step();
  endtask

  task automatic exc(input bit ex, input bit eret, input logic [4:0] t, input bit bd,
                     input logic [31:0] pc, input logic [31:0] bv);
    bus.pms_ex = ex; bus.pms_eret = eret; bus.ex_type = t; bus.pms_bd = bd;
    bus.pms_pc = pc; bus.pms_badvaddr = bv;
    step();
  endtask

  initial begin
    logic [31:0] v;
    int r;
    resetn = 1'b0;
    set_idle();
    model_reset();
    #2;
    peek(8'h60, v); chk("reset_status", v, 32'h0040_0000);
    peek(8'h48, v); chk("reset_count", v, 32'd0);
    chk("reset_has_int", {31'd0, bus.has_int}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    mtc0(1'b1, 8'h60, 32'h0000_FF01, 1'b1, 8'h60, 32'h0000_0101);
    peek(8'h60, v); chk("dual_write_status", v, 32'h0040_0101);

    exc(1'b1, 1'b0, 5'd4, 1'b1, 32'hBFC0_1004, 32'h0000_0001);
    peek(8'h70, v); chk("ex_epc_bd", v, 32'hBFC0_1000);
    peek(8'h68, v); chk("ex_cause_bd_code", v & 32'h8000_007C, 32'h8000_0010);
    peek(8'h60, v); chk("ex_exl", v & 32'h2, 32'h2);
    peek(8'h40, v); chk("ex_badvaddr", v, 32'h0000_0001);
    exc(1'b1, 1'b0, 5'd4, 1'b0, 32'h8000_0000, 32'h0000_0001);
    peek(8'h70, v); chk("ex_nested_epc_hold", v, 32'hBFC0_1000);

    exc(1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 32'd0);
    peek(8'h60, v); chk("eret_clears_exl", v & 32'h2, 32'h0);
    mtc0(1'b1, 8'h60, 32'h0000_0103, 1'b0, 8'h00, 32'd0);
    exc(1'b1, 1'b1, 5'd0, 1'b0, 32'h0000_1234, 32'd0);
    peek(8'h60, v); chk("eret_vs_ex_exl", v & 32'h2, 32'h2);

    mtc0(1'b1, 8'h60, 32'h0000_8001, 1'b0, 8'h00, 32'd0);
    mtc0(1'b1, 8'h58, 32'd5, 1'b1, 8'h48, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      peek(8'h48, v);
      if (v == 32'd5) break;
    end
    chk("timer_count_reach5", v, 32'd5);
    step();
    peek(8'h68, v); chk("timer_ti_set", v & 32'h4000_0000, 32'h4000_0000);
    chk("timer_has_int", {31'd0, bus.has_int}, 32'd1);
    mtc0(1'b1, 8'h58, 32'd100, 1'b0, 8'h00, 32'd0);
    peek(8'h68, v); chk("timer_ti_clear", v & 32'h4000_0000, 32'h0);

    mtc0(1'b1, 8'h60, 32'h0000_0101, 1'b1, 8'h68, 32'h0000_0100);
    chk("swint_has_int", {31'd0, bus.has_int}, 32'd1);
    mtc0(1'b1, 8'h60, 32'h0000_0103, 1'b0, 8'h00, 32'd0);
    chk("swint_exl_mask", {31'd0, bus.has_int}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      bus.ext_int = 6'($urandom);
      if (r < 7) begin
        bus.inst1_mtc0_we = 1'($urandom); bus.inst1_c0_addr = pick_addr();
        bus.inst1_c0_wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
        bus.inst2_mtc0_we = 1'($urandom); bus.inst2_c0_addr = pick_addr();
        bus.inst2_c0_wdata = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
      end else begin
        bus.pms_ex = (r != 8); bus.pms_eret = (r != 7);
        bus.ex_type = 5'($urandom); bus.pms_bd = 1'($urandom);
        bus.pms_pc = $urandom; bus.pms_badvaddr = $urandom;
      end
      step();
    end

    @(posedge clk);
    #3;
    resetn = 1'b0;
    model_reset();
    peek(8'h60, v); chk("midrun_reset_status", v, 32'h0040_0000);
    peek(8'h48, v); chk("midrun_reset_count", v, 32'd0);
    chk("midrun_reset_has_int", {31'd0, bus.has_int}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- MIPS coprocessor-0 register file for the dual-issue pipeline; sits beside the pre-memory stage.
- Accepts up to two mtc0 writes per cycle (inst1 older, inst2 younger), plus one exception/eret report per cycle.
- Returns combinational mfc0 read data for both slots, the EPC, and the pending-interrupt flag.
- Owns the Count/Compare timer and its timer interrupt.

Parameters:
- COUNT_DIV, 1, Count increments once every 2^COUNT_DIV cycles (1 = every other cycle).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst1_c0_wdata  in  32  mtc0 data, slot 1
- inst1_c0_addr  in  8  {rd[4:0],sel[2:0]}, slot 1
- inst1_mtc0_we  in  1  write enable, slot 1
- inst2_c0_wdata  in  32  mtc0 data, slot 2
- inst2_c0_addr  in  8  address, slot 2
- inst2_mtc0_we  in  1  write enable, slot 2
- pms_ex  in  1  exception taken this cycle
- ex_type  in  5  ExcCode
- pms_bd  in  1  excepting instruction is in a delay slot
- pms_pc  in  32  PC of the excepting instruction
- pms_badvaddr  in  32  faulting address
- pms_eret  in  1  eret retires this cycle
- ext_int  in  6  hardware interrupt lines, level-sensitive
- inst1_c0_rdata  out  32  read data at inst1_c0_addr
- inst2_c0_rdata  out  32  read data at inst2_c0_addr
- has_int  out  1  interrupt pending and enabled
- pms_epc  out  32  current EPC

Behaviour:
- Addresses:
  - BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values (async, resetn=0): Status=32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare, and the tick counter all 0.
- Status:
  - BEV[22] is constant 1.
  - IM[15:8], EXL[1], IE[0] are writable.
  - All other bits read 0.
- Cause:
  - BD[31] and TI[30] are hardware-only.
  - IP[15:10] = registered ext_int with IP[15] ORed with TI.
  - IP[9:8] are software-writable.
  - ExcCode[6:2] is hardware-only.
  - All other bits read 0.
- Writes:
  - All register updates occur at the clk rising edge.
  - inst1 and inst2 writes to different registers are both applied.
  - Same register written by both slots: inst2 value wins.
- Exception (pms_ex=1):
  - Cause.ExcCode <= ex_type.
  - If Status.EXL==0: EPC <= pms_bd ? pms_pc-4 : pms_pc, and Cause.BD <= pms_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - BadVAddr <= pms_badvaddr when ex_type is 4 (AdEL), 5 (AdES), 2 (TLBL) or 3 (TLBS).
  - Exception updates take priority over same-cycle mtc0 writes to the same fields.
- eret (pms_eret=1, pms_ex=0): Status.EXL <= 0. If both are asserted, pms_ex wins.
- Timer:
  - A tick counter of COUNT_DIV bits wraps each period; Count increments when it wraps.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - mtc0 Count overrides the increment in the same cycle; the tick counter is not reset.
  - TI is set on the edge after Count==Compare, when no Compare write occurs that cycle.
  - mtc0 Compare clears TI; clear wins over set.
- Outputs:
  - has_int = |(Cause[15:8] & Status[15:8]) & Status.IE & ~Status.EXL.
  - Read ports are combinational from current register state. There is no write-to-read bypass; same-cycle RAW is resolved by the pipeline.
  - pms_epc = EPC register.

Optional Feature:
- Macro CP0_TLB_REGS_EN.
- Defined: adds Index 8'h00 (P[31] hw-only, [3:0] rw), EntryLo0 8'h10 / EntryLo1 8'h18 ([25:0] rw), EntryHi 8'h50 (VPN2[31:13], ASID[7:0] rw).
  - TLB refill/invalid exceptions (ex_type 2/3) also load EntryHi.VPN2 <= pms_badvaddr[31:13].
  - All of these reset to 0.
- Undefined: these addresses read 0 and ignore writes.

Test Plan:
- Reset: resetn low mid-Count -> Status=32'h0040_0000, Count=0, has_int=0 immediately (asynchronous).
- Dual write: inst1 writes Status=32'h0000_FF01 and inst2 writes Status=32'h0000_0101 in the same cycle -> Status reads 32'h0040_0101.
- Exception in delay slot: pms_ex=1, ex_type=4, pms_bd=1, pms_pc=32'hBFC0_1004, badvaddr=32'h1 -> EPC=32'hBFC0_1000, BD=1, EXL=1, ExcCode=4, BadVAddr=1; a second exception with pc=32'h8000_0000 leaves EPC unchanged.
- Timer: Compare=5, Count=0, COUNT_DIV=1 -> Count reaches 5 after 10 cycles, TI=1 next edge; has_int=1 with IM7=1, IE=1, EXL=0; mtc0 Compare clears TI.
- eret: EXL=1, pms_eret=1 -> EXL=0 next edge; with pms_ex=1 also asserted, EXL stays 1.
- Software interrupt: Cause write IP[8]=1 with Status=32'h0000_0101 -> has_int=1; EXL=1 masks has_int to 0.
